// File: rtl/alu_sequencer_if.sv
// Request/response handshakes and logic-unit operand/strobe bus of the ALU sequencer.
// The slave modport is the sequencer side. The master modport is the decoder/consumer/logic-unit side.
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] bus1;
    logic [15:0] bus2;
    logic [15:0] bus3;
    logic        pass, pass_high, push, push_high;
    logic        add, sub, inc, dec, mul, shr, shl, band, bor, bxor, bnegate;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, bus3,
        output req_ready, rsp_valid, rsp_data, rsp_err, bus1, bus2,
        output pass, pass_high, push, push_high,
        output add, sub, inc, dec, mul, shr, shl, band, bor, bxor, bnegate
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, bus3,
        input  req_ready, rsp_valid, rsp_data, rsp_err, bus1, bus2,
        input  pass, pass_high, push, push_high,
        input  add, sub, inc, dec, mul, shr, shl, band, bor, bxor, bnegate
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue-side controller for the 16-bit logic unit: it takes one request at a time, strobes the unit,
// fetches the result from bus3 and returns it over a valid/ready response handshake.
module alu_sequencer (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  io
);
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_FETCH, S_PASS, S_RESP} state_t;

    state_t      state_q;
    logic [3:0]  op_q;
    logic [15:0] b_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [15:0] rsp_data_q;
    logic [15:0] bus1_q;
    logic [15:0] bus2_q;
    logic [10:0] op_strb_q;
    logic        pass_q;
    logic        pass_high_q;
    logic        push_q;
    logic [10:0] op_dec;
    logic        accept;

    // One-hot decode of the incoming opcode; bit i is the strobe for opcode i.
    for (genvar gi = 0; gi < 11; gi++) begin : g_dec
        assign op_dec[gi] = (io.req_op == 4'(gi));
    end

    assign accept = (state_q == S_IDLE) && req_ready_q && io.req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 4'd0;
            b_q         <= 16'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 16'd0;
            bus1_q      <= 16'd0;
            bus2_q      <= 16'd0;
            op_strb_q   <= 11'd0;
            pass_q      <= 1'b0;
            pass_high_q <= 1'b0;
            push_q      <= 1'b0;
        end else begin
            // Strobes and buses are single-cycle pulses unless a state sets them below.
            op_strb_q   <= 11'd0;
            pass_q      <= 1'b0;
            pass_high_q <= 1'b0;
            push_q      <= 1'b0;
            bus1_q      <= 16'd0;
            bus2_q      <= 16'd0;
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= !accept;
                    if (accept) begin
                        op_q <= io.req_op;
                        b_q  <= io.req_b;
                        if (io.req_op <= 4'd10) begin
                            state_q   <= S_EXEC;
                            bus1_q    <= io.req_a;
                            bus2_q    <= io.req_b;
                            op_strb_q <= op_dec;
                        end else if (io.req_op == 4'd11) begin
                            state_q <= S_PASS;
                            pass_q  <= 1'b1;
                            bus1_q  <= io.req_a;
                        end else if (io.req_op == 4'd12) begin
                            state_q     <= S_PASS;
                            pass_high_q <= 1'b1;
                            bus2_q      <= io.req_b;
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= 16'd0;
                        end
                    end
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    push_q  <= 1'b1;
                end
                S_FETCH: begin
                    state_q     <= S_RESP;
                    rsp_data_q  <= io.bus3;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                end
                S_PASS: begin
                    // passB never depends on the unit's output, so B is returned from the local copy.
                    state_q     <= S_RESP;
                    rsp_data_q  <= (op_q == 4'd12) ? b_q : io.bus3;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                end
                S_RESP: begin
                    if (io.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.req_ready = req_ready_q;
    assign io.rsp_valid = rsp_valid_q;
    assign io.rsp_data  = rsp_data_q;
    assign io.rsp_err   = rsp_err_q;
    assign io.bus1      = bus1_q;
    assign io.bus2      = bus2_q;
    assign io.pass      = pass_q;
    assign io.pass_high = pass_high_q;
    assign io.push      = push_q;
    assign io.push_high = 1'b0;
    assign io.add       = op_strb_q[0];
    assign io.sub       = op_strb_q[1];
    assign io.inc       = op_strb_q[2];
    assign io.dec       = op_strb_q[3];
    assign io.mul       = op_strb_q[4];
    assign io.shr       = op_strb_q[5];
    assign io.shl       = op_strb_q[6];
    assign io.band      = op_strb_q[7];
    assign io.bor       = op_strb_q[8];
    assign io.bxor      = op_strb_q[9];
    assign io.bnegate   = op_strb_q[10];
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural logic unit drives bus3, and a queue holds the
// expected responses, which are pushed at issue time and popped as the sequencer returns results.
module tb_alu_sequencer;
    logic clk;
    logic rst_n;

    alu_sequencer_if io ();

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
    } vec_t;

    rsp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural logic unit: it latches on an op strobe and presents the result while push is high.
    logic [15:0] unit_q = 16'd0;
    logic [10:0] op_vec;
    assign op_vec = {io.bnegate, io.bxor, io.bor, io.band, io.shl, io.shr,
                     io.mul, io.dec, io.inc, io.sub, io.add};
    assign io.bus3 = io.pass ? io.bus1 : (io.push ? unit_q : 16'h0000);

    always @(posedge clk) begin
        if (io.add)          unit_q <= io.bus1 + io.bus2;
        else if (io.sub)     unit_q <= io.bus1 - io.bus2;
        else if (io.inc)     unit_q <= io.bus2 + 16'd1;
        else if (io.dec)     unit_q <= io.bus2 - 16'd1;
        else if (io.mul)     unit_q <= io.bus1 * io.bus2;
        else if (io.shr)     unit_q <= io.bus1 >> io.bus2;
        else if (io.shl)     unit_q <= io.bus1 << io.bus2;
        else if (io.band)    unit_q <= io.bus1 & io.bus2;
        else if (io.bor)     unit_q <= io.bus1 | io.bus2;
        else if (io.bxor)    unit_q <= io.bus1 ^ io.bus2;
        else if (io.bnegate) unit_q <= ~io.bus2;
    end

    // Strobe activity monitor, sampled mid-cycle.
    int          op_cyc = 0, pass_cyc = 0, passh_cyc = 0, push_cyc = 0;
    int          excl_viol = 0, idle_viol = 0;
    logic [10:0] last_vec = 11'd0;
    logic [15:0] last_b1 = 16'd0, last_b2 = 16'd0;

    always @(negedge clk) begin
        if (|op_vec) begin
            op_cyc   <= op_cyc + 1;
            last_vec <= op_vec;
            last_b1  <= io.bus1;
            last_b2  <= io.bus2;
        end
        if (io.pass)      pass_cyc  <= pass_cyc + 1;
        if (io.pass_high) passh_cyc <= passh_cyc + 1;
        if (io.push)      push_cyc  <= push_cyc + 1;
        if ($countones({op_vec, io.pass, io.pass_high}) > 1 || io.push_high)
            excl_viol <= excl_viol + 1;
        if (!(|op_vec) && !io.pass && !io.pass_high && (io.bus1 != 16'd0 || io.bus2 != 16'd0))
            idle_viol <= idle_viol + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output bit ok);
        io.req_op    = op;
        io.req_a     = a;
        io.req_b     = b;
        io.req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (io.req_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        io.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!io.rsp_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    function automatic vec_t alu_vec(input int i);
        vec_t v;
        case (i)
            0:  v = '{4'd0,  16'h1234, 16'h0001, 16'h1235};
            1:  v = '{4'd1,  16'h0000, 16'h0001, 16'hFFFF};
            2:  v = '{4'd4,  16'h0100, 16'h0100, 16'h0000};
            3:  v = '{4'd6,  16'h0001, 16'h0004, 16'h0010};
            4:  v = '{4'd5,  16'h8000, 16'h0010, 16'h0000};
            5:  v = '{4'd2,  16'h0000, 16'hFFFF, 16'h0000};
            6:  v = '{4'd3,  16'h0000, 16'h0000, 16'hFFFF};
            7:  v = '{4'd7,  16'hF0F0, 16'hFF00, 16'hF000};
            8:  v = '{4'd8,  16'h00F0, 16'h0F00, 16'h0FF0};
            9:  v = '{4'd10, 16'h1234, 16'h00FF, 16'hFF00};
            10: v = '{4'd4,  16'h0003, 16'h0005, 16'h000F};
            default: v = '{4'd5, 16'h8000, 16'h0003, 16'h1000};
        endcase
        return v;
    endfunction

    task automatic test_reset();
        io.req_valid = 1'b0;
        io.req_op    = 4'd0;
        io.req_a     = 16'd0;
        io.req_b     = 16'd0;
        io.rsp_ready = 1'b1;
        rst_n        = 1'b0;
        step();
        step();
        n_checks++; if (io.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b required 0", io.req_ready); end
        n_checks++; if (io.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", io.rsp_valid); end
        n_checks++; if (io.rsp_data !== 16'd0 || io.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got data %h err %b required 0000/0", io.rsp_data, io.rsp_err); end
        n_checks++; if (io.bus1 !== 16'd0 || io.bus2 !== 16'd0) begin n_fail++; $display("FAIL reset_bus: got %h/%h required 0000/0000", io.bus1, io.bus2); end
        n_checks++; if ({op_vec, io.pass, io.pass_high, io.push, io.push_high} !== 15'd0) begin n_fail++; $display("FAIL reset_strobes: got %b required 0", {op_vec, io.pass, io.pass_high, io.push, io.push_high}); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (io.req_ready !== 1'b0) begin n_fail++; $display("FAIL release_req_ready: got %b required 0", io.req_ready); end
        step();
        n_checks++; if (io.req_ready !== 1'b1) begin n_fail++; $display("FAIL first_edge_req_ready: got %b required 1", io.req_ready); end
    endtask

    task automatic test_alu_ops();
        vec_t        v;
        rsp_t        exp;
        int          lat, op0, push0, pass0;
        bit          ok;
        logic [10:0] ev;
        io.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            v     = alu_vec(i);
            op0   = op_cyc;
            push0 = push_cyc;
            pass0 = pass_cyc + passh_cyc;
            sb_q.push_back('{v.r, 1'b0});
            issue(v.op, v.a, v.b, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL alu%0d_accept: got no accept required accept", i); end
            wait_rsp(lat);
            n_checks++; if (lat != 3) begin n_fail++; $display("FAIL alu%0d_latency: got %0d required 3", i, lat); end
            if (sb_q.size() == 0) begin
                n_checks++; n_fail++; $display("FAIL alu%0d_scoreboard: got empty queue required entry", i);
            end else begin
                exp = sb_q.pop_front();
                n_checks++; if (io.rsp_data !== exp.data) begin n_fail++; $display("FAIL alu%0d_data op %0d: got %h required %h", i, v.op, io.rsp_data, exp.data); end
                n_checks++; if (io.rsp_err !== exp.err) begin n_fail++; $display("FAIL alu%0d_err: got %b required %b", i, io.rsp_err, exp.err); end
            end
            ev = 11'd1 << v.op;
            n_checks++; if (op_cyc - op0 != 1 || last_vec !== ev) begin n_fail++; $display("FAIL alu%0d_strobe: got %0d cycles vec %b required 1 cycle vec %b", i, op_cyc - op0, last_vec, ev); end
            n_checks++; if (last_b1 !== v.a || last_b2 !== v.b) begin n_fail++; $display("FAIL alu%0d_operands: got %h/%h required %h/%h", i, last_b1, last_b2, v.a, v.b); end
            n_checks++; if (push_cyc - push0 != 1 || pass_cyc + passh_cyc - pass0 != 0) begin n_fail++; $display("FAIL alu%0d_push: got push %0d pass %0d required 1/0", i, push_cyc - push0, pass_cyc + passh_cyc - pass0); end
            step();
            n_checks++; if (io.rsp_valid !== 1'b0 || io.req_ready !== 1'b1) begin n_fail++; $display("FAIL alu%0d_handshake: got valid %b ready %b required 0/1", i, io.rsp_valid, io.req_ready); end
        end
    endtask

    task automatic test_pass();
        rsp_t exp;
        int   lat, op0, p0, ph0, push0;
        bit   ok;
        for (int i = 0; i < 2; i++) begin
            op0 = op_cyc; p0 = pass_cyc; ph0 = passh_cyc; push0 = push_cyc;
            sb_q.push_back('{(i == 0) ? 16'hBEEF : 16'hCAFE, 1'b0});
            if (i == 0) issue(4'd11, 16'hBEEF, 16'h1357, ok);
            else        issue(4'd12, 16'h1111, 16'hCAFE, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL pass%0d_accept: got no accept required accept", i); end
            wait_rsp(lat);
            n_checks++; if (lat != 2) begin n_fail++; $display("FAIL pass%0d_latency: got %0d required 2", i, lat); end
            exp = sb_q.pop_front();
            n_checks++; if (io.rsp_data !== exp.data || io.rsp_err !== 1'b0) begin n_fail++; $display("FAIL pass%0d_data: got %h err %b required %h err 0", i, io.rsp_data, io.rsp_err, exp.data); end
            n_checks++; if (pass_cyc - p0 != ((i == 0) ? 1 : 0) || passh_cyc - ph0 != ((i == 0) ? 0 : 1)) begin n_fail++; $display("FAIL pass%0d_strobe: got pass %0d pass_high %0d required %0d/%0d", i, pass_cyc - p0, passh_cyc - ph0, (i == 0) ? 1 : 0, (i == 0) ? 0 : 1); end
            n_checks++; if (op_cyc != op0 || push_cyc != push0) begin n_fail++; $display("FAIL pass%0d_no_op: got op %0d push %0d required 0/0", i, op_cyc - op0, push_cyc - push0); end
            step();
        end
    endtask

    task automatic test_illegal();
        int         lat, s0;
        bit         ok;
        logic [3:0] op;
        for (int i = 13; i < 16; i++) begin
            op = 4'(i);
            s0 = op_cyc + pass_cyc + passh_cyc + push_cyc;
            sb_q.push_back('{16'h0000, 1'b1});
            issue(op, 16'hA5A5, 16'h5A5A, ok);
            wait_rsp(lat);
            n_checks++; if (!ok || lat != 1) begin n_fail++; $display("FAIL illegal%0d_latency: got accept %b lat %0d required 1/1", i, ok, lat); end
            if (sb_q.size() != 0) begin
                rsp_t exp;
                exp = sb_q.pop_front();
                n_checks++; if (io.rsp_data !== exp.data || io.rsp_err !== exp.err) begin n_fail++; $display("FAIL illegal%0d_rsp: got %h err %b required %h err %b", i, io.rsp_data, io.rsp_err, exp.data, exp.err); end
            end
            step();
            n_checks++; if (op_cyc + pass_cyc + passh_cyc + push_cyc != s0) begin n_fail++; $display("FAIL illegal%0d_strobes: got %0d strobe cycles required 0", i, op_cyc + pass_cyc + passh_cyc + push_cyc - s0); end
        end
    endtask

    task automatic test_backpressure();
        rsp_t exp;
        int   lat;
        bit   ok;
        io.rsp_ready = 1'b0;
        sb_q.push_back('{16'hF0F0, 1'b0});
        issue(4'd9, 16'hFF00, 16'h0FF0, ok);
        wait_rsp(lat);
        n_checks++; if (!ok || lat != 3) begin n_fail++; $display("FAIL bp_latency: got accept %b lat %0d required 1/3", ok, lat); end
        io.req_op = 4'd0; io.req_a = 16'h0001; io.req_b = 16'h0002; io.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (io.rsp_valid !== 1'b1 || io.rsp_data !== 16'hF0F0 || io.rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d: got valid %b data %h err %b required 1/f0f0/0", i, io.rsp_valid, io.rsp_data, io.rsp_err); end
            n_checks++; if (io.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready%0d: got %b required 0", i, io.req_ready); end
            step();
        end
        exp = sb_q.pop_front();
        n_checks++; if (io.rsp_data !== exp.data) begin n_fail++; $display("FAIL bp_data: got %h required %h", io.rsp_data, exp.data); end
        io.rsp_ready = 1'b1;
        step();
        n_checks++; if (io.rsp_valid !== 1'b0 || io.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid %b ready %b required 0/1", io.rsp_valid, io.req_ready); end
        sb_q.push_back('{16'h0003, 1'b0});
        step();
        io.req_valid = 1'b0;
        n_checks++; if (io.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: got ready %b required 0", io.req_ready); end
        wait_rsp(lat);
        exp = sb_q.pop_front();
        n_checks++; if (lat != 3 || io.rsp_data !== exp.data) begin n_fail++; $display("FAIL bp_second_rsp: got lat %0d data %h required 3/%h", lat, io.rsp_data, exp.data); end
        step();
    endtask

    task automatic test_back_to_back();
        vec_t v[3];
        rsp_t exp;
        int   idx, got_n, last_acc;
        bit   acc;
        v[0] = '{4'd0, 16'h0005, 16'h0003, 16'h0008};
        v[1] = '{4'd1, 16'h0005, 16'h0003, 16'h0002};
        v[2] = '{4'd8, 16'hA000, 16'h000A, 16'hA00A};
        idx = 0; got_n = 0; last_acc = -1;
        io.rsp_ready = 1'b1;
        io.req_op = v[0].op; io.req_a = v[0].a; io.req_b = v[0].b; io.req_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && got_n < 3; cyc++) begin
            if (io.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_scoreboard: got response %h with empty queue required none", io.rsp_data);
                end else begin
                    exp = sb_q.pop_front();
                    n_checks++; if (io.rsp_data !== exp.data || io.rsp_err !== exp.err) begin n_fail++; $display("FAIL b2b_data%0d: got %h err %b required %h err %b", got_n, io.rsp_data, io.rsp_err, exp.data, exp.err); end
                end
                got_n++;
            end
            acc = io.req_valid && io.req_ready;
            step();
            if (acc) begin
                sb_q.push_back('{v[idx].r, 1'b0});
                if (last_acc >= 0) begin
                    n_checks++; if (cyc - last_acc != 4) begin n_fail++; $display("FAIL b2b_interval%0d: got %0d cycles required 4", idx, cyc - last_acc); end
                end
                last_acc = cyc;
                idx++;
                if (idx < 3) begin
                    io.req_op = v[idx].op; io.req_a = v[idx].a; io.req_b = v[idx].b;
                end else begin
                    io.req_valid = 1'b0;
                end
            end
        end
        io.req_valid = 1'b0;
        n_checks++; if (got_n != 3) begin n_fail++; $display("FAIL b2b_count: got %0d responses required 3", got_n); end
    endtask

    task automatic test_reset_abort();
        int vcnt;
        bit ok;
        io.rsp_ready = 1'b1;
        issue(4'd0, 16'h1234, 16'h0001, ok);
        step();
        n_checks++; if (!ok || io.push !== 1'b1) begin n_fail++; $display("FAIL abort_in_fetch: got accept %b push %b required 1/1", ok, io.push); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (io.rsp_valid !== 1'b0 || io.push !== 1'b0 || io.bus1 !== 16'd0 || io.req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_async: got valid %b push %b bus1 %h ready %b required 0/0/0000/0", io.rsp_valid, io.push, io.bus1, io.req_ready); end
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_checks++; if (io.req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_release_ready: got %b required 0", io.req_ready); end
        step();
        n_checks++; if (io.req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready_edge: got %b required 1", io.req_ready); end
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (io.rsp_valid) vcnt++;
            step();
        end
        n_checks++; if (vcnt != 0) begin n_fail++; $display("FAIL abort_stale_rsp: got %0d valid cycles required 0", vcnt); end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_pass();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        n_checks++; if (excl_viol != 0) begin n_fail++; $display("FAIL strobe_exclusive: got %0d violating cycles required 0", excl_viol); end
        n_checks++; if (idle_viol != 0) begin n_fail++; $display("FAIL bus_idle_zero: got %0d violating cycles required 0", idle_viol); end
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries required 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the 16-bit logic unit. It accepts one ALU request at a time over a valid/ready handshake and drives operands onto bus1/bus2 with a one-hot operation strobe. It then asserts the result-push strobe, captures the low 16-bit result from bus3 and returns it over a second valid/ready handshake. It sits between instruction decode and the logic unit and is the only driver of the unit's strobes and operand buses.

## Interface
- No parameters; data width fixed at 16.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  4  opcode (see Operation)
- req_a  in  16  operand A (to bus1)
- req_b  in  16  operand B (to bus2)
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  result
- rsp_err  out  1  illegal opcode flag, qualified by rsp_valid
- bus1, bus2  out  16  operand buses to logic unit
- bus3  in  16  result bus from logic unit
- pass, pass_high, push, add, sub, inc, dec, mul, shr, shl, band, bor, bxor, bnegate  out  1 each  logic-unit strobes
- push_high  out  1  tied 0 (high half not used)

## Operation
- Opcodes:
  - 0 add, 1 sub, 2 inc(B), 3 dec(B), 4 mul, 5 shr (A>>B), 6 shl (A<<B)
  - 7 and, 8 or, 9 xor, 10 not(B)
  - 11 passA: bus3=bus1, same cycle
  - 12 passB: route via pass_high; the result is A-independent and rsp_data=req_b captured internally
  - 13–15 illegal
- States:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready and latch op/A/B.
    - Legal ALU op (0–10) → EXEC.
    - 11/12 → PASS.
    - Illegal → RESP with rsp_err=1, rsp_data=0.
  - EXEC: one cycle. bus1=A, bus2=B, exactly one op strobe high; the logic unit latches at the closing edge. → FETCH.
  - FETCH: one cycle. push=1, bus1=bus2=0. Sample bus3 into rsp_data at the closing edge, rsp_err=0. → RESP.
  - PASS: one cycle.
    - Op 11: pass=1, bus1=A; capture bus3.
    - Op 12: pass_high=1, bus2=B; rsp_data=B.
    - → RESP.
  - RESP: rsp_valid=1, and rsp_data/rsp_err are held stable. On rsp_ready → IDLE.
- Strobes are decoded from registered state and op. At most one of the op/pass strobes plus push is high in any cycle, and never two op strobes together.
- Width rules are set by the logic unit and passed through unmodified:
  - Results are modulo 2^16.
  - mul returns the low 16 bits.
  - Shift counts ≥16 yield 0.
  - not(B) returns ~B.
- New requests are ignored (req_ready=0) in every state except IDLE. A/B/op are not resampled.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE
  - req_ready=0, becomes 1 on the first rising edge after release
  - rsp_valid=0, rsp_data=0, rsp_err=0
  - bus1=bus2=0, all strobes 0
- Accept at edge T:
  - ALU op: EXEC in cycle T..T+1, FETCH in T+1..T+2, rsp_valid high from T+2 (3rd cycle after accept).
  - Pass op: rsp_valid from T+1.
  - Illegal op: rsp_valid from T, i.e. the cycle right after accept.
- rsp_valid holds until the edge where rsp_ready=1. req_ready rises the cycle after that handshake.
- Peak throughput is one ALU op per 4 cycles, with rsp_ready tied 1.
- Reset asserted mid-EXEC/FETCH/RESP aborts the operation. All outputs return to reset values immediately and no response is produced.
- bus1/bus2 are 0 whenever not in EXEC/PASS.

## Test plan
- Op 0, A=0x1234, B=0x0001, rsp_ready=1 → rsp_data=0x1235, rsp_err=0, rsp_valid exactly 3 cycles after accept; add strobe high exactly one cycle with bus1=0x1234.
- Op 1, A=0x0000, B=0x0001 → 0xFFFF. Op 4, A=B=0x0100 → 0x0000. Op 6, A=0x0001, B=4 → 0x0010. Op 5, A=0x8000, B=16 → 0x0000.
- Op 11, A=0xBEEF → rsp_data=0xBEEF, 2 cycles after accept, pass high one cycle, no op strobe.
- Op 14 → rsp_err=1, rsp_data=0, 1 cycle after accept, no strobe ever asserted.
- Back-pressure: op 9 A=0xFF00 B=0x0FF0, rsp_ready low 5 cycles → rsp_data=0xF0F0 stable, req_ready=0 throughout. A second req_valid held during that window is accepted only the cycle after the handshake.
- Drop rst_n during FETCH → rsp_valid, push, bus1 go 0 immediately. After release, req_ready=1 one edge later and no stale response appears.
